// File: rtl/song_mem_pkg.sv
// rtl/song_mem_pkg.sv - shared types and width helpers for the song memory bank
package song_mem_pkg;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_NUM_SLOTS  = 4;
    localparam int DEF_SLOT_DEPTH = 256;
    localparam int DEF_SW         = clog2(DEF_NUM_SLOTS);
    localparam int DEF_PW         = clog2(DEF_SLOT_DEPTH);

endpackage

// File: rtl/slot_ram.sv
// rtl/slot_ram.sv - single-port synchronous song RAM, preloaded slots served from a build-time table
module slot_ram
    import song_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int SLOT_DEPTH  = DEF_SLOT_DEPTH,
    parameter int PRE_WRITTEN = 1,
    parameter int AW          = DEF_SW + DEF_PW
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int PW = clog2(SLOT_DEPTH);

    logic [DATA_WIDTH-1:0] mem [NUM_SLOTS*SLOT_DEPTH];
    logic                  preloaded;

    // Built-in tunes: word k of a preloaded slot is k+1, never writable.
    assign preloaded = (32'(addr) >> PW) < 32'(PRE_WRITTEN);

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= preloaded ? DATA_WIDTH'(32'(addr[PW-1:0]) + 32'd1) : mem[addr];
    end

endmodule

// File: rtl/song_memory_bank.sv
// rtl/song_memory_bank.sv - multi-slot song recorder/player with length tracking and valid/ready playback
module song_memory_bank
    import song_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_SLOTS   = 4,
    parameter int SLOT_DEPTH  = 256,
    parameter int PRE_WRITTEN = 1,
    parameter int PRE_LEN     = 64,
    localparam int SW = clog2(NUM_SLOTS),
    localparam int PW = clog2(SLOT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rec_start,
    input  logic                  rec_valid,
    input  logic [DATA_WIDTH-1:0] rec_data,
    input  logic                  rec_stop,
    input  logic                  abort,
    input  logic                  play_start,
    input  logic [SW-1:0]         play_slot,
    input  logic                  play_ready,
    output logic                  play_valid,
    output logic [DATA_WIDTH-1:0] play_data,
    output logic                  play_last,
    output logic [SW:0]           slot_count,
    output logic                  full_flag,
    output logic                  rec_overflow,
    output logic                  cmd_err,
    output logic                  busy
);
    state_t                state, state_n;
    logic [SW-1:0]         wr_slot, rd_slot;
    logic [PW:0]           wr_ptr, wr_ptr_n, rd_ptr, beat_cnt;
    logic [PW:0]           len [NUM_SLOTS];
    logic                  out_valid, out_valid_n, skid_valid, skid_valid_n, inflight;
    logic [DATA_WIDTH-1:0] out_data, out_data_n, skid_data, skid_data_n, ram_rdata;
    logic                  cmd_err_n, commit, rec_go, play_go, ram_we, flush, issue;
    logic                  accept, write_ok;
    logic [1:0]            occ;
    logic [SW+PW-1:0]      ram_addr;

    assign full_flag  = (slot_count == (SW+1)'(NUM_SLOTS));
    assign busy       = (state != IDLE);
    assign play_valid = out_valid;
    assign play_data  = out_data;
    assign play_last  = out_valid && (beat_cnt == len[rd_slot] - 1'b1);
    assign accept     = out_valid && play_ready;
    assign write_ok   = rec_valid && (wr_ptr < (PW+1)'(SLOT_DEPTH));
    assign wr_ptr_n   = wr_ptr + (PW+1)'(ram_we);
    // Words held or in flight after this cycle's handoff; reads issue while it stays below two.
    assign occ        = 2'(out_valid) + 2'(skid_valid) + 2'(inflight) - 2'(accept);
    assign ram_addr   = (state == RECORD) ? {wr_slot, wr_ptr[PW-1:0]} : {rd_slot, rd_ptr[PW-1:0]};

    slot_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_DEPTH (SLOT_DEPTH),
        .PRE_WRITTEN(PRE_WRITTEN),
        .AW         (SW + PW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(rec_data),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_n   = state;
        cmd_err_n = 1'b0;
        commit    = 1'b0;
        rec_go    = 1'b0;
        play_go   = 1'b0;
        ram_we    = 1'b0;
        flush     = 1'b0;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                if (abort || rec_stop) begin
                    state_n = IDLE;
                end else if (rec_start) begin
                    if (full_flag) cmd_err_n = 1'b1;
                    else begin
                        rec_go  = 1'b1;
                        state_n = RECORD;
                    end
                end else if (play_start) begin
                    if ({1'b0, play_slot} >= slot_count) cmd_err_n = 1'b1;
                    else begin
                        play_go = 1'b1;
                        state_n = PLAY;
                    end
                end
            end
            RECORD: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    ram_we = write_ok;
                    if (rec_stop) begin
                        state_n = IDLE;
                        commit  = (wr_ptr_n != '0);
                    end else if (rec_start || play_start) begin
                        cmd_err_n = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (abort) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else begin
                    if (rec_start) cmd_err_n = 1'b1;
                    issue = (rd_ptr < len[rd_slot]) && (occ < 2'd2);
                    if (accept && play_last) begin
                        state_n = IDLE;
                        flush   = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        if (!out_valid || accept) begin
            if (skid_valid) begin
                out_valid_n  = 1'b1;
                out_data_n   = skid_data;
                skid_valid_n = inflight;
                skid_data_n  = ram_rdata;
            end else begin
                out_valid_n = inflight;
                if (inflight) out_data_n = ram_rdata;
            end
        end else if (inflight) begin
            skid_valid_n = 1'b1;
            skid_data_n  = ram_rdata;
        end
        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_slot      <= '0;
            wr_ptr       <= '0;
            rd_slot      <= '0;
            rd_ptr       <= '0;
            beat_cnt     <= '0;
            slot_count   <= (SW+1)'(PRE_WRITTEN);
            rec_overflow <= 1'b0;
            cmd_err      <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            inflight     <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len[i] <= (i < PRE_WRITTEN) ? (PW+1)'(PRE_LEN) : '0;
            end
        end else begin
            state      <= state_n;
            cmd_err    <= cmd_err_n;
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            inflight   <= issue;
            if (rec_go) begin
                wr_slot      <= slot_count[SW-1:0];
                wr_ptr       <= '0;
                rec_overflow <= 1'b0;
            end else if (state == RECORD && !abort) begin
                wr_ptr <= wr_ptr_n;
                if (rec_valid && !write_ok) rec_overflow <= 1'b1;
            end
            if (commit) begin
                len[wr_slot] <= wr_ptr_n;
                slot_count   <= slot_count + 1'b1;
            end
            if (play_go) begin
                rd_slot  <= play_slot;
                rd_ptr   <= '0;
                beat_cnt <= '0;
            end else begin
                if (issue)  rd_ptr   <= rd_ptr + 1'b1;
                if (accept) beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_song_memory_bank.sv
// tb/tb_song_memory_bank.sv - scoreboard bench for song_memory_bank against a slot-queue model
module tb_song_memory_bank;
    localparam int NS   = 4;
    localparam int SD   = 256;
    localparam int PRE  = 1;
    localparam int PLEN = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rec_start = 1'b0, rec_valid = 1'b0, rec_stop = 1'b0, abort = 1'b0;
    logic       play_start = 1'b0, play_ready = 1'b0;
    logic [7:0] rec_data = '0;
    logic [1:0] play_slot = '0;
    logic       play_valid, play_last, full_flag, rec_overflow, cmd_err, busy;
    logic [7:0] play_data;
    logic [2:0] slot_count;

    song_memory_bank dut (
        .clk(clk), .rst_n(rst_n), .rec_start(rec_start), .rec_valid(rec_valid),
        .rec_data(rec_data), .rec_stop(rec_stop), .abort(abort), .play_start(play_start),
        .play_slot(play_slot), .play_ready(play_ready), .play_valid(play_valid),
        .play_data(play_data), .play_last(play_last), .slot_count(slot_count),
        .full_flag(full_flag), .rec_overflow(rec_overflow), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] mslot[NS][$];
    int         mcount;
    int         checks = 0;
    int         errors = 0;
    int         err_seen = 0;
    bit         no_stall_chk = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) mslot[s].delete();
        for (int k = 0; k < PLEN; k++) mslot[0].push_back(8'(k + 1));
        mcount = PRE;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_err) err_seen++;
            if (!no_stall_chk && prev_stall) begin
                chk("stall_valid_held", play_valid, 1);
                chk("stall_data_held", play_data, prev_data);
            end
            if (play_valid && play_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h with no beat expected", play_data);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("play_data", play_data, b.d);
                    chk("play_last", play_last, b.l);
                end
            end
            prev_stall = play_valid && !play_ready;
            prev_data  = play_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_record(input int n, input bit stop_with_last, input bit rnd,
                             input logic [7:0] base, input bit with_play);
        int         e0;
        logic [7:0] words[$];
        logic [7:0] d;
        e0 = err_seen;
        rec_start = 1'b1;
        play_start = with_play;
        play_slot = '0;
        step();
        rec_start = 1'b0;
        play_start = 1'b0;
        if (mcount == NS) begin
            step();
            chk("full_rec_cmd_err", err_seen - e0, 1);
            chk("full_flag", full_flag, 1);
            chk("full_busy", busy, 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            d = rnd ? 8'($urandom) : 8'(base + i);
            rec_valid = 1'b1;
            rec_data  = d;
            if (stop_with_last && i == n - 1) rec_stop = 1'b1;
            step();
            if (i == SD - 1) chk("no_overflow_at_depth", rec_overflow, 0);
            if (i == SD)     chk("overflow_after_257", rec_overflow, 1);
            if (words.size() < SD) words.push_back(d);
        end
        rec_valid = 1'b0;
        if (!stop_with_last || n == 0) begin
            rec_stop = 1'b1;
            step();
        end
        rec_stop = 1'b0;
        if (words.size() > 0) begin
            mslot[mcount] = words;
            mcount++;
        end
        step();
        chk("slot_count", slot_count, mcount);
        chk("full_flag", full_flag, mcount == NS);
        chk("rec_busy_done", busy, 0);
        chk("rec_no_cmd_err", err_seen - e0, 0);
    endtask

    task automatic do_play(input int slot, input bit rnd);
        int e0, n, cnt;
        e0 = err_seen;
        play_slot  = 2'(slot);
        play_start = 1'b1;
        play_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        play_start = 1'b0;
        if (slot >= mcount) begin
            step();
            chk("play_bad_slot_cmd_err", err_seen - e0, 1);
            chk("play_bad_slot_busy", busy, 0);
            play_ready = 1'b0;
            return;
        end
        n = mslot[slot].size();
        for (int k = 0; k < n; k++) exp_q.push_back('{d: mslot[slot][k], l: (k == n - 1)});
        chk("latency_cycle1", play_valid, 0);
        if (rnd) play_ready = 1'($urandom_range(0, 1));
        step();
        chk("latency_cycle2", play_valid, 0);
        if (rnd) play_ready = 1'($urandom_range(0, 1));
        step();
        chk("latency_first_valid", play_valid, 1);
        cnt = 0;
        while ((exp_q.size() > 0 || busy) && cnt < 5000) begin
            if (rnd) play_ready = 1'($urandom_range(0, 1));
            step();
            cnt++;
        end
        if (cnt >= 5000) begin
            checks++;
            errors++;
            $display("FAIL play_timeout: %0d beats still outstanding", exp_q.size());
            exp_q.delete();
        end
        play_ready = 1'b0;
        step();
        chk("play_valid_after_done", play_valid, 0);
        chk("play_no_cmd_err", err_seen - e0, 0);
    endtask

    initial begin
        int e0;
        model_reset();
        step();
        step();
        chk("rst_slot_count", slot_count, PRE);
        chk("rst_full_flag", full_flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_play_valid", play_valid, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_rec_overflow", rec_overflow, 0);
        rst_n = 1'b1;
        step();

        do_play(0, 1'b0);
        do_record(5, 1'b1, 1'b0, 8'h11, 1'b0);
        do_play(1, 1'b0);
        do_record(260, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("overflow_sticky_after_stop", rec_overflow, 1);
        do_play(2, 1'b0);
        do_play(3, 1'b0);

        rec_start = 1'b1;
        step();
        rec_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rec_valid = 1'b1;
            rec_data  = 8'($urandom);
            step();
        end
        rec_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("abort_rec_busy", busy, 0);
        chk("abort_rec_slot_count", slot_count, mcount);

        do_record(0, 1'b0, 1'b0, 8'h00, 1'b0);
        do_record(12, 1'b0, 1'b1, 8'h00, 1'b1);
        do_record(3, 1'b0, 1'b1, 8'h00, 1'b0);

        do_play(3, 1'b1);
        do_play(2, 1'b1);
        do_play(1, 1'b1);
        do_play(0, 1'b1);

        e0 = err_seen;
        play_slot  = 2'd2;
        play_start = 1'b1;
        play_ready = 1'b1;
        step();
        play_start = 1'b0;
        for (int k = 0; k < mslot[2].size(); k++)
            exp_q.push_back('{d: mslot[2][k], l: (k == mslot[2].size() - 1)});
        repeat (5) step();
        rec_start = 1'b1;
        step();
        rec_start = 1'b0;
        step();
        chk("rec_in_play_cmd_err", err_seen - e0, 1);
        chk("rec_in_play_busy", busy, 1);
        no_stall_chk = 1'b1;
        play_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("abort_play_busy", busy, 0);
        chk("abort_play_valid", play_valid, 0);
        step();
        no_stall_chk = 1'b0;

        play_slot  = 2'd3;
        play_start = 1'b1;
        play_ready = 1'b1;
        step();
        play_start = 1'b0;
        for (int k = 0; k < mslot[3].size(); k++)
            exp_q.push_back('{d: mslot[3][k], l: (k == mslot[3].size() - 1)});
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_play_valid", play_valid, 0);
        chk("async_rst_slot_count", slot_count, PRE);
        chk("async_rst_busy", busy, 0);
        exp_q.delete();
        model_reset();
        play_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        do_play(1, 1'b0);
        do_play(0, 1'b1);
        do_record(4, 1'b0, 1'b1, 8'h00, 1'b0);
        do_play(1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
